dcache_assoc: RTL



---
 rtl/dcache_assoc.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_assoc.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_assoc
//  Purpose  : N-way set-associative, write-back, write-allocate data cache
//             with tree-PLRU replacement and saturating hit/miss counters.
//             Sits in the MEM stage between the pipeline and block memory.
//  Ports    : CLK, RESET (sync, active-low)
//             CPU side    : MEM_READ, MEM_WRITE, MEM_ADDRESS, DATA_IN,
//                           CACHE_READ_OUT, BUSYWAIT
//             Memory side : MEM_MEM_READ, MEM_MEM_WRITE, MEM_BLOCK_ADDR,
//                           MEM_WRITE_OUT, MEM_READ_OUT, MEM_BUSYWAIT
//             Statistics  : HIT_COUNT, MISS_COUNT
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_assoc #(
   parameter int WAYS        = 2,
   parameter int SETS        = 8,
   parameter int BLOCK_WORDS = 4,
   parameter int ADDR_W      = 32
) (
   input  logic                                       CLK,
   input  logic                                       RESET,
   input  logic                                       MEM_READ,
   input  logic                                       MEM_WRITE,
   input  logic [ADDR_W-1:0]                          MEM_ADDRESS,
   input  logic [31:0]                                DATA_IN,
   output logic [31:0]                                CACHE_READ_OUT,
   output logic                                       BUSYWAIT,
   output logic                                       MEM_MEM_READ,
   output logic                                       MEM_MEM_WRITE,
   output logic [ADDR_W-3-$clog2(BLOCK_WORDS):0]      MEM_BLOCK_ADDR,
   output logic [32*BLOCK_WORDS-1:0]                  MEM_WRITE_OUT,
   input  logic [32*BLOCK_WORDS-1:0]                  MEM_READ_OUT,
   input  logic                                       MEM_BUSYWAIT,
   output logic [31:0]                                HIT_COUNT,
   output logic [31:0]                                MISS_COUNT
);

   localparam int OFF_W  = $clog2(BLOCK_WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int BLK_W  = 32 * BLOCK_WORDS;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_FETCH     = 2'd2,
      S_UPDATE    = 2'd3
   } state_t;

   state_t                 r_state;
   logic [WAYS-1:0]        r_valid [SETS];
   logic [WAYS-1:0]        r_dirty [SETS];
   logic [PLRU_W-1:0]      r_plru  [SETS];
   logic [TAG_W-1:0]       r_tag   [SETS][WAYS];
   logic [BLK_W-1:0]       r_data  [SETS][WAYS];

   // Miss context, captured on leaving IDLE so a changing or dropped CPU
   // request cannot disturb an in-flight fill.
   logic [WAY_W-1:0]       r_victim;
   logic [TAG_W-1:0]       r_req_tag;
   logic [IDX_W-1:0]       r_req_idx;
   logic [BLK_W-1:0]       r_fill;

   logic                   r_mem_read;
   logic                   r_mem_write;
   logic [TAG_W+IDX_W-1:0] r_block_addr;
   logic [BLK_W-1:0]       r_write_out;
   logic [31:0]            r_hit_count;
   logic [31:0]            r_miss_count;

   logic [TAG_W-1:0]       w_tag;
   logic [IDX_W-1:0]       w_idx;
   logic [OFF_W-1:0]       w_off;
   logic                   w_req;
   logic                   w_hit;
   logic [WAY_W-1:0]       w_hit_idx;
   logic [WAY_W-1:0]       w_victim;
   logic [WAY_W-1:0]       w_plru_victim;
   logic [PLRU_W-1:0]      w_plru_cur;
   logic [PLRU_W-1:0]      w_plru_next;
   logic [BLK_W-1:0]       w_hit_blk;
   logic                   w_idle_hit;

   assign w_tag      = MEM_ADDRESS[ADDR_W-1 -: TAG_W];
   assign w_idx      = MEM_ADDRESS[2+OFF_W +: IDX_W];
   assign w_off      = MEM_ADDRESS[2 +: OFF_W];
   assign w_req      = MEM_READ | MEM_WRITE;
   assign w_plru_cur = r_plru[w_idx];
   assign w_hit_blk  = r_data[w_idx][w_hit_idx];
   assign w_idle_hit = (r_state == S_IDLE) && w_hit;

   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_idx = WAY_W'(w);
         end
      end
   end

   // Descending scan leaves the lowest-numbered invalid way selected.
   always_comb begin
      w_victim = w_plru_victim;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
      end
   end

   // Tree PLRU: each node bit points towards the half holding the victim;
   // an access flips every node on its path to point away from it.
   generate
      if (WAYS == 4) begin : g_plru_4
         assign w_plru_victim = w_plru_cur[0] ? {1'b1, w_plru_cur[2]}
                                              : {1'b0, w_plru_cur[1]};
         always_comb begin
            w_plru_next    = w_plru_cur;
            w_plru_next[0] = ~w_hit_idx[1];
            if (w_hit_idx[1]) w_plru_next[2] = ~w_hit_idx[0];
            else              w_plru_next[1] = ~w_hit_idx[0];
         end
      end else if (WAYS == 2) begin : g_plru_2
         assign w_plru_victim = w_plru_cur;
         assign w_plru_next   = ~w_hit_idx;
      end else begin : g_plru_1
         assign w_plru_victim = '0;
         assign w_plru_next   = '0;
      end
   endgenerate

   assign BUSYWAIT       = w_req && !w_idle_hit;
   assign CACHE_READ_OUT = (w_req && w_idle_hit) ? w_hit_blk[{w_off, 5'b0} +: 32] : 32'd0;
   assign MEM_MEM_READ   = r_mem_read;
   assign MEM_MEM_WRITE  = r_mem_write;
   assign MEM_BLOCK_ADDR = r_block_addr;
   assign MEM_WRITE_OUT  = r_write_out;
   assign HIT_COUNT      = r_hit_count;
   assign MISS_COUNT     = r_miss_count;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state      <= S_IDLE;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_plru[s]  <= '0;
         end
         r_victim     <= '0;
         r_req_tag    <= '0;
         r_req_idx    <= '0;
         r_fill       <= '0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_block_addr <= '0;
         r_write_out  <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req && w_hit) begin
                  if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
                  r_plru[w_idx] <= w_plru_next;
                  if (MEM_WRITE) r_dirty[w_idx][w_hit_idx] <= 1'b1;
               end else if (w_req) begin
                  if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
                  r_victim  <= w_victim;
                  r_req_tag <= w_tag;
                  r_req_idx <= w_idx;
                  if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                     r_state      <= S_WRITEBACK;
                     r_mem_write  <= 1'b1;
                     r_block_addr <= {r_tag[w_idx][w_victim], w_idx};
                     r_write_out  <= r_data[w_idx][w_victim];
                  end else begin
                     r_state      <= S_FETCH;
                     r_mem_read   <= 1'b1;
                     r_block_addr <= {w_tag, w_idx};
                  end
               end
            end
            S_WRITEBACK: begin
               if (!MEM_BUSYWAIT) begin
                  r_state      <= S_FETCH;
                  r_mem_write  <= 1'b0;
                  r_write_out  <= '0;
                  r_mem_read   <= 1'b1;
                  r_block_addr <= {r_req_tag, r_req_idx};
               end
            end
            S_FETCH: begin
               if (!MEM_BUSYWAIT) begin
                  r_state      <= S_UPDATE;
                  r_mem_read   <= 1'b0;
                  r_block_addr <= '0;
                  r_fill       <= MEM_READ_OUT;
               end
            end
            S_UPDATE: begin
               r_state                       <= S_IDLE;
               r_valid[r_req_idx][r_victim] <= 1'b1;
               r_dirty[r_req_idx][r_victim] <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; their contents are meaningless
   // until the matching valid bit is set.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         if (w_req && w_idle_hit && MEM_WRITE) begin
            r_data[w_idx][w_hit_idx][{w_off, 5'b0} +: 32] <= DATA_IN;
         end else if (r_state == S_UPDATE) begin
            r_data[r_req_idx][r_victim] <= r_fill;
            r_tag[r_req_idx][r_victim]  <= r_req_tag;
         end
      end
   end

endmodule
`default_nettype wire
